// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Multi-cycle core controller. Walks one instruction at a time through
//   FETCH -> DECODE -> EXEC -> (MEM) -> WRITE. Each stage gets a one-cycle
//   start pulse on entry, after which the controller waits for that
//   stage's done level. Owns the architectural PC, the retired-instruction
//   counter and trap entry (illegal instr, misaligned target, stage hang).
//
// Ports
//   i_clk, i_rstn           clock / async active-low reset
//   i_run                   level, 1 = keep issuing instructions
//   o_<stage>_en            one-cycle start pulse per stage
//   i_<stage>_done          stage completion level
//   i_illegal               valid with i_decode_done
//   i_is_mem_op             valid with i_exec_done
//   i_branch_taken/_target  valid with i_exec_done
//   o_pc                    PC of the instruction in flight
//   o_state                 IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WRITE=5 TRAP=6
//   o_trap                  one-cycle pulse on trap entry
//   o_trap_cause            0 none, 1 illegal, 2 misaligned, 3 hang (sticky)
//   o_instret               retired-instruction count
`timescale 1ns/1ps
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_run,
  output logic        o_fetch_en,
  input  logic        i_fetch_done,
  output logic        o_decode_en,
  input  logic        i_decode_done,
  input  logic        i_illegal,
  output logic        o_exec_en,
  input  logic        i_exec_done,
  input  logic        i_is_mem_op,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic        o_mem_en,
  input  logic        i_mem_done,
  output logic        o_write_en,
  input  logic        i_write_done,
  output logic [31:0] o_pc,
  output logic [2:0]  o_state,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WRITE  = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Last wait-cycle count before a hang trap fires.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [4:0]  r_en;       // {write, mem, exec, decode, fetch}
  logic        r_trap;
  logic [1:0]  r_cause;
  logic [15:0] r_wait;
  logic [31:0] r_pc;
  logic [31:0] r_next_pc;
  logic [31:0] r_instret;

  state_t      w_nxt;
  logic        w_done;
  logic        w_en_cycle;
  logic        w_stage;
  logic        w_trap_go;
  logic [1:0]  w_cause;
  logic        w_retire;
  logic        w_latch;
  logic [31:0] w_npc;

  // Any en bit high means this is the first cycle of a stage; done is
  // ignored there because it may still be stale from an earlier request.
  assign w_en_cycle = |r_en;
  assign w_npc      = i_branch_taken ? i_branch_target : r_pc + 32'd4;

  always_comb begin
    w_done  = 1'b0;
    w_stage = 1'b1;
    case (r_state)
      S_FETCH:  w_done = i_fetch_done;
      S_DECODE: w_done = i_decode_done;
      S_EXEC:   w_done = i_exec_done;
      S_MEM:    w_done = i_mem_done;
      S_WRITE:  w_done = i_write_done;
      default:  w_stage = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt     = r_state;
    w_trap_go = 1'b0;
    w_cause   = 2'd0;
    w_retire  = 1'b0;
    w_latch   = 1'b0;
    case (r_state)
      S_IDLE: if (i_run) w_nxt = S_FETCH;
      S_TRAP: w_nxt = i_run ? S_FETCH : S_IDLE;
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WRITE: begin
        if (!w_en_cycle) begin
          if (w_done) begin
            case (r_state)
              S_FETCH:  w_nxt = S_DECODE;
              S_DECODE: begin
                if (i_illegal) begin
                  w_trap_go = 1'b1;
                  w_cause   = 2'd1;
                end else begin
                  w_nxt = S_EXEC;
                end
              end
              S_EXEC: begin
                w_latch = 1'b1;
                if (i_branch_taken && (i_branch_target[1:0] != 2'b00)) begin
                  w_trap_go = 1'b1;
                  w_cause   = 2'd2;
                end else begin
                  w_nxt = i_is_mem_op ? S_MEM : S_WRITE;
                end
              end
              S_MEM:   w_nxt = S_WRITE;
              S_WRITE: begin
                w_retire = 1'b1;
                w_nxt    = i_run ? S_FETCH : S_IDLE;
              end
              default: w_nxt = S_IDLE;
            endcase
          end else if (r_wait == TO_LAST) begin
            // done arriving in the last allowed cycle is handled above and wins
            w_trap_go = 1'b1;
            w_cause   = 2'd3;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_trap_go) w_nxt = S_TRAP;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state   <= S_IDLE;
      r_en      <= 5'd0;
      r_trap    <= 1'b0;
      r_cause   <= 2'd0;
      r_wait    <= 16'd0;
      r_pc      <= RESET_PC;
      r_next_pc <= 32'd0;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_nxt;
      r_trap  <= w_trap_go;
      // Every stage entry is a real state change (no stage re-enters itself),
      // so the pulse is simply "next state differs and is that stage".
      r_en[0] <= (w_nxt == S_FETCH)  && (r_state != S_FETCH);
      r_en[1] <= (w_nxt == S_DECODE) && (r_state != S_DECODE);
      r_en[2] <= (w_nxt == S_EXEC)   && (r_state != S_EXEC);
      r_en[3] <= (w_nxt == S_MEM)    && (r_state != S_MEM);
      r_en[4] <= (w_nxt == S_WRITE)  && (r_state != S_WRITE);
      if (w_nxt != r_state)
        r_wait <= 16'd0;
      else if (w_stage && !w_en_cycle)
        r_wait <= r_wait + 16'd1;
      if (w_latch) r_next_pc <= w_npc;
      if (w_trap_go) begin
        r_cause <= w_cause;
        r_pc    <= TRAP_VEC;
      end else if (w_retire) begin
        r_pc      <= r_next_pc;
        r_instret <= r_instret + 32'd1;
      end
    end
  end

  assign o_fetch_en   = r_en[0];
  assign o_decode_en  = r_en[1];
  assign o_exec_en    = r_en[2];
  assign o_mem_en     = r_en[3];
  assign o_write_en   = r_en[4];
  assign o_trap       = r_trap;
  assign o_trap_cause = r_cause;
  assign o_state      = r_state;
  assign o_pc         = r_pc;
  assign o_instret    = r_instret;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer
//   Directed instruction stream with per-stage done latencies. A stage
//   responder answers each en pulse after a programmed delay; a behavioural
//   model advances through the stage rules and is compared against every
//   DUT output on every cycle. Literal checks pin key results.
`timescale 1ns/1ps
module tb_stage_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
  localparam int          TIMEOUT  = 4;

  typedef struct {
    int          d_f, d_d, d_e, d_m, d_w; // done delay after en, 0 = never
    bit          ill, mem, br;
    logic [31:0] tgt;
  } desc_t;

  logic        clk = 1'b0, rstn = 1'b0, run = 1'b0;
  logic [5:1]  done = '0;  // 1 fetch .. 5 write
  logic        illegal = 1'b0, is_mem = 1'b0, br = 1'b0;
  logic [31:0] tgt = '0;
  logic        fetch_en, decode_en, exec_en, mem_en, write_en, trap;
  logic [31:0] pc, instret;
  logic [2:0]  state;
  logic [1:0]  cause;
  logic [5:1]  en_vec;

  int n_chk = 0, n_pass = 0;
  desc_t q[$];
  desc_t cur;
  int    cnt[1:5];

  // model
  int          m_st, m_wait;
  bit          m_first;
  logic [31:0] m_pc, m_npc, m_inst;
  logic [1:0]  m_cause;
  logic [5:1]  e_en;
  logic        e_trap;

  always #5 clk = ~clk;

  stage_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_run(run),
    .o_fetch_en(fetch_en), .i_fetch_done(done[1]),
    .o_decode_en(decode_en), .i_decode_done(done[2]), .i_illegal(illegal),
    .o_exec_en(exec_en), .i_exec_done(done[3]), .i_is_mem_op(is_mem),
    .i_branch_taken(br), .i_branch_target(tgt),
    .o_mem_en(mem_en), .i_mem_done(done[4]),
    .o_write_en(write_en), .i_write_done(done[5]),
    .o_pc(pc), .o_state(state), .o_trap(trap), .o_trap_cause(cause),
    .o_instret(instret)
  );

  assign en_vec = {write_en, mem_en, exec_en, decode_en, fetch_en};

  function automatic desc_t mk(int f, int d, int e, int m, int w,
                               bit il, bit mo, bit b, logic [31:0] t);
    desc_t x;
    x.d_f = f; x.d_d = d; x.d_e = e; x.d_m = m; x.d_w = w;
    x.ill = il; x.mem = mo; x.br = b; x.tgt = t;
    return x;
  endfunction

  function automatic int dly(desc_t x, int s);
    case (s)
      1: return x.d_f;
      2: return x.d_d;
      3: return x.d_e;
      4: return x.d_m;
      default: return x.d_w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  task m_reset();
    m_st = 0; m_wait = 0; m_first = 0;
    m_pc = RESET_PC; m_npc = '0; m_inst = '0; m_cause = '0;
    e_en = '0; e_trap = 1'b0;
  endtask

  task go(input int s);
    m_st = s; m_wait = 0;
    m_first = (s >= 1 && s <= 5);
    if (m_first) e_en[s] = 1'b1;
  endtask

  task enter_trap(input logic [1:0] c);
    m_st = 6; m_wait = 0; m_first = 0;
    e_trap = 1'b1; m_cause = c; m_pc = TRAP_VEC;
  endtask

  task stage_done();
    case (m_st)
      1: go(2);
      2: if (illegal) enter_trap(2'd1); else go(3);
      3: begin
        m_npc = br ? tgt : m_pc + 32'd4;
        if (br && tgt[1:0] != 2'b00) enter_trap(2'd2);
        else go(is_mem ? 4 : 5);
      end
      4: go(5);
      default: begin
        m_pc = m_npc; m_inst = m_inst + 32'd1;
        go(run ? 1 : 0);
      end
    endcase
  endtask

  // Uses this cycle's inputs to predict next cycle's outputs.
  task m_step();
    e_en = '0; e_trap = 1'b0;
    case (m_st)
      0: if (run) go(1);
      6: go(run ? 1 : 0);
      default: begin
        if (m_first) m_first = 0;
        else if (done[m_st]) stage_done();
        else begin
          m_wait++;
          if (m_wait == TIMEOUT) enter_trap(2'd3);
        end
      end
    endcase
  endtask

  task cmp_all();
    chk("en_pulses", 32'(en_vec), 32'(e_en));
    chk("trap", 32'(trap), 32'(e_trap));
    chk("state", 32'(state), 32'(m_st));
    chk("pc", pc, m_pc);
    chk("trap_cause", 32'(cause), 32'(m_cause));
    chk("instret", instret, m_inst);
  endtask

  // compare, respond to en pulses, then advance the model
  always @(negedge clk) begin
    if (!rstn) begin
      m_reset();
      for (int s = 1; s <= 5; s++) cnt[s] = 0;
      done = '0;
      cmp_all();
    end else begin
      cmp_all();
      for (int s = 1; s <= 5; s++) begin
        if (en_vec[s]) begin
          if (s == 1) cur = (q.size() > 0) ? q.pop_front() : mk(1,1,1,1,1,0,0,0,0);
          cnt[s] = dly(cur, s);
          done[s] = 1'b0;
        end else if (cnt[s] > 0) begin
          cnt[s]--;
          done[s] = (cnt[s] == 0);
        end else begin
          done[s] = 1'b0;
        end
      end
      illegal = cur.ill; is_mem = cur.mem; br = cur.br; tgt = cur.tgt;
      m_step();
    end
  end

  // kind 0: instret==val, 1: trap pulse, 2: state==val
  task automatic wait_for(input int kind, input logic [31:0] val, input string nm);
    bit hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk); #2;
      case (kind)
        0: hit = (instret == val);
        1: hit = (trap == 1'b1);
        default: hit = (32'(state) == val);
      endcase
    end
    n_chk++;
    if (hit) n_pass++;
    else $display("FAIL wait %s: condition not reached, expected %h", nm, val);
  endtask

  initial begin
    cur = mk(1,1,1,1,1,0,0,0,0);
    m_reset();
    q.push_back(mk(1,1,1,1,1, 0,0,0, 32'h0));   // A plain
    q.push_back(mk(2,1,3,2,1, 0,1,0, 32'h0));   // B mem op
    q.push_back(mk(1,2,1,1,1, 0,0,1, 32'h80));  // C branch 0x80
    q.push_back(mk(1,1,2,1,1, 0,1,1, 32'h82));  // D misaligned target
    q.push_back(mk(1,1,1,1,1, 1,0,0, 32'h0));   // E illegal
    q.push_back(mk(1,1,4,1,1, 0,0,0, 32'h0));   // F done on last allowed cycle
    q.push_back(mk(1,1,0,1,1, 0,0,0, 32'h0));   // G exec hangs
    q.push_back(mk(1,1,1,3,1, 0,1,0, 32'h0));   // H mem op, run drops in MEM

    repeat (3) @(posedge clk);
    #2;
    chk("reset state", 32'(state), 32'd0);
    chk("reset pc", pc, RESET_PC);
    chk("reset instret", instret, 32'd0);
    chk("reset fetch_en", 32'(fetch_en), 32'd0);
    rstn = 1'b1; run = 1'b1;
    @(posedge clk); #2;
    chk("first fetch_en", 32'(fetch_en), 32'd1);

    wait_for(0, 32'd1, "A retire");
    chk("A pc", pc, 32'h4);
    chk("A refetch", 32'(fetch_en), 32'd1);

    wait_for(0, 32'd3, "C retire");
    chk("C pc", pc, 32'h80);

    wait_for(1, 32'd1, "D trap");
    chk("D cause", 32'(cause), 32'd2);
    chk("D instret", instret, 32'd3);
    @(posedge clk); #2;
    chk("D pc", pc, TRAP_VEC);
    chk("D refetch", 32'(state), 32'd1);

    wait_for(1, 32'd1, "E trap");
    chk("E cause", 32'(cause), 32'd1);
    chk("E instret", instret, 32'd3);

    wait_for(0, 32'd4, "F retire");
    chk("F pc", pc, 32'h104);

    wait_for(1, 32'd1, "G trap");
    chk("G cause", 32'(cause), 32'd3);

    wait_for(2, 32'd4, "H in MEM");
    run = 1'b0;
    wait_for(2, 32'd0, "H idle");
    chk("H instret", instret, 32'd5);
    chk("H pc", pc, 32'h104);

    run = 1'b1;
    wait_for(2, 32'd3, "reach EXEC");
    rstn = 1'b0;
    #1;
    chk("async state", 32'(state), 32'd0);
    chk("async pc", pc, RESET_PC);
    chk("async instret", instret, 32'd0);
    chk("async cause", 32'(cause), 32'd0);
    @(posedge clk); #2;
    run = 1'b0;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
